// File: rtl/axi4_host_pkg.sv
// Shared constants and FSM state encoding for the AXI4 host initiator.
package axi4_host_pkg;

  localparam logic [1:0] BURST_INCR  = 2'b01;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Bufferable + modifiable, normal non-cacheable memory
  localparam logic [3:0] CACHE_BUF_MOD = 4'b0011;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    RSP     = 3'd5
  } state_t;

endpackage

// File: rtl/axi4_host_master.sv
// Single-outstanding AXI4 initiator: one cmd -> one single-beat AXI
// read or write -> one rsp. Flags ID mismatches and missing RLAST.
module axi4_host_master
  import axi4_host_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  // command
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ID_WIDTH-1:0]   cmd_id,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [STRB_WIDTH-1:0] cmd_wstrb,
  // response
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [ID_WIDTH-1:0]   rsp_id,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  proto_err,
  // AW
  output logic                  axi_awvalid,
  input  logic                  axi_awready,
  output logic [ID_WIDTH-1:0]   axi_awid,
  output logic [ADDR_WIDTH-1:0] axi_awaddr,
  output logic [7:0]            axi_awlen,
  output logic [2:0]            axi_awsize,
  output logic [1:0]            axi_awburst,
  output logic                  axi_awlock,
  output logic [3:0]            axi_awcache,
  output logic [2:0]            axi_awprot,
  // W
  output logic                  axi_wvalid,
  input  logic                  axi_wready,
  output logic [DATA_WIDTH-1:0] axi_wdata,
  output logic [STRB_WIDTH-1:0] axi_wstrb,
  output logic                  axi_wlast,
  // B
  input  logic                  axi_bvalid,
  output logic                  axi_bready,
  input  logic [ID_WIDTH-1:0]   axi_bid,
  input  logic [1:0]            axi_bresp,
  // AR
  output logic                  axi_arvalid,
  input  logic                  axi_arready,
  output logic [ID_WIDTH-1:0]   axi_arid,
  output logic [ADDR_WIDTH-1:0] axi_araddr,
  output logic [7:0]            axi_arlen,
  output logic [2:0]            axi_arsize,
  output logic [1:0]            axi_arburst,
  output logic                  axi_arlock,
  output logic [3:0]            axi_arcache,
  output logic [2:0]            axi_arprot,
  // R
  input  logic                  axi_rvalid,
  output logic                  axi_rready,
  input  logic [ID_WIDTH-1:0]   axi_rid,
  input  logic [DATA_WIDTH-1:0] axi_rdata,
  input  logic [1:0]            axi_rresp,
  input  logic                  axi_rlast
);

  localparam logic [2:0] AXSIZE = 3'($clog2(STRB_WIDTH));

  state_t              state;
  logic [ID_WIDTH-1:0] cur_id;
  logic                aw_done, w_done;

  // Fixed single-beat transfer attributes
  assign axi_awlen   = 8'd0;
  assign axi_awsize  = AXSIZE;
  assign axi_awburst = BURST_INCR;
  assign axi_awlock  = 1'b0;
  assign axi_awcache = CACHE_BUF_MOD;
  assign axi_awprot  = 3'b000;
  assign axi_wlast   = 1'b1;
  assign axi_arlen   = 8'd0;
  assign axi_arsize  = AXSIZE;
  assign axi_arburst = BURST_INCR;
  assign axi_arlock  = 1'b0;
  assign axi_arcache = CACHE_BUF_MOD;
  assign axi_arprot  = 3'b000;

  // A channel counts as done once its handshake happened earlier (valid
  // already dropped) or happens in this cycle.
  assign aw_done = !axi_awvalid || axi_awready;
  assign w_done  = !axi_wvalid  || axi_wready;

  // Command/AXI/response FSM with all outputs registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cmd_ready   <= 1'b0;
      cur_id      <= '0;
      axi_awvalid <= 1'b0;
      axi_awid    <= '0;
      axi_awaddr  <= '0;
      axi_wvalid  <= 1'b0;
      axi_wdata   <= '0;
      axi_wstrb   <= '0;
      axi_bready  <= 1'b0;
      axi_arvalid <= 1'b0;
      axi_arid    <= '0;
      axi_araddr  <= '0;
      axi_rready  <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_write   <= 1'b0;
      rsp_id      <= '0;
      rsp_rdata   <= '0;
      rsp_resp    <= '0;
      proto_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            cur_id    <= cmd_id;
            rsp_write <= cmd_write;
            if (cmd_write) begin
              axi_awvalid <= 1'b1;
              axi_awid    <= cmd_id;
              axi_awaddr  <= cmd_addr;
              axi_wvalid  <= 1'b1;
              axi_wdata   <= cmd_wdata;
              axi_wstrb   <= cmd_wstrb;
              state       <= WR_REQ;
            end else begin
              axi_arvalid <= 1'b1;
              axi_arid    <= cmd_id;
              axi_araddr  <= cmd_addr;
              state       <= RD_REQ;
            end
          end
        end
        WR_REQ: begin
          if (axi_awready) axi_awvalid <= 1'b0;
          if (axi_wready)  axi_wvalid  <= 1'b0;
          if (aw_done && w_done) begin
            axi_bready <= 1'b1;
            state      <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (axi_bvalid) begin
            axi_bready <= 1'b0;
            rsp_id     <= axi_bid;
            rsp_resp   <= axi_bresp;
            rsp_rdata  <= '0;
            rsp_valid  <= 1'b1;
            if (axi_bid != cur_id) proto_err <= 1'b1;
            state      <= RSP;
          end
        end
        RD_REQ: begin
          if (axi_arready) begin
            axi_arvalid <= 1'b0;
            axi_rready  <= 1'b1;
            state       <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (axi_rvalid) begin
            axi_rready <= 1'b0;
            rsp_id     <= axi_rid;
            rsp_resp   <= axi_rresp;
            rsp_rdata  <= axi_rdata;
            rsp_valid  <= 1'b1;
            if (axi_rid != cur_id || !axi_rlast) proto_err <= 1'b1;
            state      <= RSP;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_host_master.sv
// Directed bench for axi4_host_master: hand-computed expectations per step.
module tb_axi4_host_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 0, cmd_ready, cmd_write = 0;
  logic [7:0]  cmd_id = 0;
  logic [15:0] cmd_addr = 0;
  logic [31:0] cmd_wdata = 0;
  logic [3:0]  cmd_wstrb = 0;
  logic        rsp_valid, rsp_ready = 0, rsp_write;
  logic [7:0]  rsp_id;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        proto_err;
  logic        awvalid, awready = 0;
  logic [7:0]  awid, awlen, arid, arlen;
  logic [15:0] awaddr, araddr;
  logic [2:0]  awsize, awprot, arsize, arprot;
  logic [1:0]  awburst, arburst;
  logic        awlock, arlock;
  logic [3:0]  awcache, arcache;
  logic        wvalid, wready = 0, wlast;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid = 0, bready;
  logic [7:0]  bid = 0;
  logic [1:0]  bresp = 0;
  logic        arvalid, arready = 0;
  logic        rvalid = 0, rready, rlast = 0;
  logic [7:0]  rid = 0;
  logic [31:0] rdata = 0;
  logic [1:0]  rresp = 0;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  axi4_host_master dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_id(cmd_id), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_id(rsp_id), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .proto_err(proto_err),
    .axi_awvalid(awvalid), .axi_awready(awready), .axi_awid(awid), .axi_awaddr(awaddr),
    .axi_awlen(awlen), .axi_awsize(awsize), .axi_awburst(awburst), .axi_awlock(awlock),
    .axi_awcache(awcache), .axi_awprot(awprot),
    .axi_wvalid(wvalid), .axi_wready(wready), .axi_wdata(wdata), .axi_wstrb(wstrb),
    .axi_wlast(wlast),
    .axi_bvalid(bvalid), .axi_bready(bready), .axi_bid(bid), .axi_bresp(bresp),
    .axi_arvalid(arvalid), .axi_arready(arready), .axi_arid(arid), .axi_araddr(araddr),
    .axi_arlen(arlen), .axi_arsize(arsize), .axi_arburst(arburst), .axi_arlock(arlock),
    .axi_arcache(arcache), .axi_arprot(arprot),
    .axi_rvalid(rvalid), .axi_rready(rready), .axi_rid(rid), .axi_rdata(rdata),
    .axi_rresp(rresp), .axi_rlast(rlast)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full read with an always-ready responder; entered with cmd_ready expected high.
  task automatic run_read(input logic [7:0] id, input logic [15:0] addr,
                          input logic [7:0] r_id, input logic [31:0] r_data,
                          input logic r_last, input logic [1:0] r_resp,
                          input logic exp_err);
    chk("rd_cmd_ready", 64'(cmd_ready), 64'd1);
    cmd_valid = 1; cmd_write = 0; cmd_id = id; cmd_addr = addr;
    arready = 1; rvalid = 1; rid = r_id; rdata = r_data; rlast = r_last; rresp = r_resp;
    tick();
    cmd_valid = 0;
    chk("rd_arvalid",  64'(arvalid), 64'd1);
    chk("rd_araddr",   64'(araddr),  64'(addr));
    chk("rd_arid",     64'(arid),    64'(id));
    chk("rd_arsize",   64'(arsize),  64'd2);
    chk("rd_rready_0", 64'(rready),  64'd0);
    tick();
    chk("rd_rready",   64'(rready),  64'd1);
    chk("rd_arvalid0", 64'(arvalid), 64'd0);
    tick();
    chk("rd_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("rd_rsp_write", 64'(rsp_write), 64'd0);
    chk("rd_rsp_id",    64'(rsp_id),    64'(r_id));
    chk("rd_rsp_rdata", 64'(rsp_rdata), 64'(r_data));
    chk("rd_rsp_resp",  64'(rsp_resp),  64'(r_resp));
    chk("rd_proto_err", 64'(proto_err), 64'(exp_err));
    rvalid = 0; arready = 0;
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    chk("rd_rsp_done", 64'(rsp_valid), 64'd0);
    chk("rd_idle",     64'(cmd_ready), 64'd1);
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst_valids", 64'({awvalid, wvalid, arvalid, bready, rready, rsp_valid}), 64'd0);
    chk("rst_addr", 64'({awaddr, araddr, wdata, awid, arid}), 64'd0);
    chk("rst_proto_err", 64'(proto_err), 64'd0);
    rst = 0;
    tick();
    chk("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);

    // 1: best-case write; bvalid already high is ignored until bready
    cmd_valid = 1; cmd_write = 1; cmd_id = 8'd5; cmd_addr = 16'h0010;
    cmd_wdata = 32'hDEADBEEF; cmd_wstrb = 4'hF;
    awready = 1; wready = 1; bvalid = 1; bid = 8'd5; bresp = 2'b00;
    tick();
    cmd_valid = 0;
    chk("wr_awvalid", 64'(awvalid), 64'd1);
    chk("wr_wvalid",  64'(wvalid),  64'd1);
    chk("wr_awaddr",  64'(awaddr),  64'h0010);
    chk("wr_wdata",   64'(wdata),   64'hDEADBEEF);
    chk("wr_wstrb",   64'(wstrb),   64'hF);
    chk("wr_wlast",   64'(wlast),   64'd1);
    chk("wr_awsize",  64'(awsize),  64'd2);
    chk("wr_fixed",   64'({awlen, awburst, awlock, awcache, awprot}), 64'({8'd0, 2'b01, 1'b0, 4'b0011, 3'b000}));
    chk("wr_bready0", 64'(bready),  64'd0);
    tick();
    chk("wr_bready",  64'(bready),  64'd1);
    chk("wr_aw_drop", 64'({awvalid, wvalid}), 64'd0);
    tick();
    chk("wr_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("wr_rsp_write", 64'(rsp_write), 64'd1);
    chk("wr_rsp_id",    64'(rsp_id),    64'd5);
    chk("wr_rsp_resp",  64'(rsp_resp),  64'd0);
    chk("wr_rsp_rdata", 64'(rsp_rdata), 64'd0);
    bvalid = 0; awready = 0; wready = 0;
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    chk("wr_rsp_done", 64'(rsp_valid), 64'd0);

    // 2: best-case read
    run_read(8'd3, 16'h0020, 8'd3, 32'h12345678, 1'b1, 2'b00, 1'b0);

    // 3: awready delayed, wready immediate
    cmd_valid = 1; cmd_write = 1; cmd_id = 8'd9; cmd_addr = 16'h0A5C;
    cmd_wdata = 32'hCAFE0001; cmd_wstrb = 4'h3;
    awready = 0; wready = 1;
    tick();
    cmd_valid = 0;
    chk("dly_cycle1", 64'({awvalid, wvalid}), 64'b11);
    for (int i = 2; i <= 4; i++) begin
      tick();
      chk("dly_awvalid_hold", 64'(awvalid), 64'd1);
      chk("dly_awaddr_hold",  64'(awaddr),  64'h0A5C);
      chk("dly_wvalid_drop",  64'(wvalid),  64'd0);
      chk("dly_bready_low",   64'(bready),  64'd0);
    end
    awready = 1;
    tick();
    awready = 0;
    chk("dly_aw_done", 64'(awvalid), 64'd0);
    chk("dly_bready",  64'(bready),  64'd1);
    bvalid = 1; bid = 8'd9; bresp = 2'b10;
    tick();
    chk("dly_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("dly_bready_off", 64'(bready),   64'd0);
    chk("dly_rsp_resp",  64'(rsp_resp),  64'd2);
    chk("dly_rsp_id",    64'(rsp_id),    64'd9);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    bvalid = 0;
    chk("dly_one_rsp", 64'(rsp_valid), 64'd0);
    tick();
    chk("dly_no_extra_rsp", 64'(rsp_valid), 64'd0);
    chk("dly_proto_ok", 64'(proto_err), 64'd0);

    // 4: rid mismatch then rlast=0; error sticky, responses delivered
    run_read(8'd3, 16'h0040, 8'd7, 32'h0BADF00D, 1'b1, 2'b00, 1'b1);
    run_read(8'd4, 16'h0044, 8'd4, 32'h55AA55AA, 1'b0, 2'b11, 1'b1);

    // 5: rsp_ready held low 5 cycles while next cmd waits
    cmd_valid = 1; cmd_write = 1; cmd_id = 8'h21; cmd_addr = 16'h1000;
    cmd_wdata = 32'h01020304; cmd_wstrb = 4'h1;
    awready = 1; wready = 1; bvalid = 1; bid = 8'h21; bresp = 2'b01;
    tick();
    cmd_write = 0; cmd_id = 8'h22; cmd_addr = 16'h2000;
    chk("hold_cmd_ready_wr", 64'(cmd_ready), 64'd0);
    tick(); tick();
    bvalid = 0;
    for (int i = 0; i < 5; i++) begin
      chk("hold_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("hold_rsp_fields", 64'({rsp_write, rsp_id, rsp_resp}), 64'({1'b1, 8'h21, 2'b01}));
      chk("hold_cmd_ready", 64'(cmd_ready), 64'd0);
      chk("hold_no_ar", 64'(arvalid), 64'd0);
      tick();
    end
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    chk("hold_next_ready", 64'(cmd_ready), 64'd1);
    chk("hold_no_ar_yet", 64'(arvalid), 64'd0);
    arready = 1; rvalid = 1; rid = 8'h22; rdata = 32'h77778888; rlast = 1; rresp = 0;
    tick();
    cmd_valid = 0;
    chk("hold_next_ar", 64'(arvalid), 64'd1);
    chk("hold_next_addr", 64'(araddr), 64'h2000);
    tick(); tick();
    chk("hold_next_rdata", 64'(rsp_rdata), 64'h77778888);
    rvalid = 0; arready = 0; awready = 0; wready = 0;
    rsp_ready = 1;
    tick();
    rsp_ready = 0;

    // 6: reset asserted in WR_RESP
    cmd_valid = 1; cmd_write = 1; cmd_id = 8'd6; cmd_addr = 16'h0030;
    cmd_wdata = 32'h11112222; cmd_wstrb = 4'hF;
    awready = 1; wready = 1; bvalid = 0;
    tick();
    cmd_valid = 0;
    tick();
    chk("rr_in_wr_resp", 64'(bready), 64'd1);
    #2 rst = 1;
    #1;
    chk("rr_valids_off", 64'({awvalid, wvalid, bready, rsp_valid}), 64'd0);
    chk("rr_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rr_proto_clr", 64'(proto_err), 64'd0);
    awready = 0; wready = 0;
    tick();
    rst = 0;
    tick();
    chk("rr_no_rsp", 64'(rsp_valid), 64'd0);
    run_read(8'd8, 16'h0050, 8'd8, 32'hA5A5F00F, 1'b1, 2'b00, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

  // Global watchdog so the bench can never hang
  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, expected run to finish");
    $fatal(1, "timeout");
  end

endmodule
